pix_stream_gen: RTL

Synthetic image-sensor transmitter that drives the parallel pixel interface (frame-valid / line-valid / 12-bit data) in the pix_clk domain. It is the source end of the interface consumed by the pixel FIFO/capture logic. It is used as the sensor model in simulation and as an on-chip test pattern source. It emits fixed-geometry frames with programmable blanking and a deterministic, checkable pixel ramp.

---
 rtl/pix_stream_gen.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/pix_stream_gen.sv
// Synthetic pixel-interface source: fixed-geometry frames with a 12-bit pixel ramp.
// Latency: en seen in Idle raises pix_frameValid right after that same clock edge.
// Backpressure: none. The sink must accept every cycle, and a started frame always finishes.
//
// Ports:
//   pix_clk, pix_rst  - pixel clock (rising edge) and async active-high reset
//   en                - level; sampled only in Idle and on the last VBlank cycle
//   pix_frameValid    - frame valid
//   pix_lineValid     - line valid
//   pix_d[11:0]       - pixel data, 0 outside lines
//   frameCount[15:0]  - completed frames, wraps
//   frameDone         - one-cycle pulse on the last VBlank cycle
//   busy              - high outside Idle
module pix_stream_gen #(
  parameter int ImageWidth  = 16,
  parameter int ImageHeight = 4,
  parameter int HBlankLen   = 4,
  parameter int VBlankLen   = 8,
  parameter int FVSetup     = 2,
  parameter int FVHold      = 2
) (
  input  logic        pix_clk,
  input  logic        pix_rst,
  input  logic        en,
  output logic        pix_frameValid,
  output logic        pix_lineValid,
  output logic [11:0] pix_d,
  output logic [15:0] frameCount,
  output logic        frameDone,
  output logic        busy
);

  // One shared phase counter serves every timed state, so it is sized for the longest one.
  localparam int P1   = (ImageWidth > HBlankLen) ? ImageWidth : HBlankLen;
  localparam int P2   = (VBlankLen > FVSetup) ? VBlankLen : FVSetup;
  localparam int P3   = (P1 > P2) ? P1 : P2;
  localparam int LMAX = (P3 > FVHold) ? P3 : FVHold;
  localparam int CW   = (LMAX > 1) ? $clog2(LMAX) : 1;
  localparam int RW   = (ImageHeight > 1) ? $clog2(ImageHeight) : 1;

  localparam logic [CW-1:0] W_LAST  = CW'(ImageWidth - 1);
  localparam logic [CW-1:0] HB_LAST = CW'(HBlankLen - 1);
  localparam logic [CW-1:0] VB_LAST = CW'(VBlankLen - 1);
  localparam logic [CW-1:0] SU_LAST = CW'(FVSetup - 1);
  localparam logic [CW-1:0] HO_LAST = CW'(FVHold - 1);
  localparam logic [RW-1:0] R_LAST  = RW'(ImageHeight - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_LINE, S_HBLANK, S_HOLD, S_VBLANK
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [RW-1:0] r_row, w_row_nxt;
  logic [11:0]   r_ramp, w_ramp_nxt;
  logic          r_fv, w_fv_nxt;
  logic          r_lv, w_lv_nxt;
  logic [11:0]   r_d, w_d_nxt;
  logic [15:0]   r_fc, w_fc_nxt;
  logic          r_done, w_done_nxt;
  logic          r_busy, w_busy_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_row_nxt   = r_row;
    w_ramp_nxt  = r_ramp;
    w_fc_nxt    = r_fc;
    w_done_nxt  = 1'b0;
    w_d_nxt     = 12'd0;

    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (en) begin
          w_state_nxt = S_SETUP;
          w_ramp_nxt  = 12'd0;
        end
      end
      S_SETUP: begin
        if (r_cnt == SU_LAST) begin
          w_state_nxt = S_LINE;
          w_cnt_nxt   = '0;
          w_row_nxt   = '0;
        end
      end
      S_LINE: begin
        if (r_cnt == W_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = (r_row == R_LAST) ? S_HOLD : S_HBLANK;
        end
      end
      S_HBLANK: begin
        if (r_cnt == HB_LAST) begin
          w_state_nxt = S_LINE;
          w_cnt_nxt   = '0;
          w_row_nxt   = r_row + 1'b1;
        end
      end
      S_HOLD: begin
        if (r_cnt == HO_LAST) begin
          w_state_nxt = S_VBLANK;
          w_cnt_nxt   = '0;
        end
      end
      S_VBLANK: begin
        if (r_cnt == VB_LAST) begin
          w_cnt_nxt = '0;
          if (en) begin
            w_state_nxt = S_SETUP;
            w_ramp_nxt  = 12'd0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    // Outputs are decoded from the next state so they register together with it.
    // The ramp holds the value of the next pixel to emit and wraps naturally at 12 bits.
    if (w_state_nxt == S_LINE) begin
      w_d_nxt    = w_ramp_nxt;
      w_ramp_nxt = w_ramp_nxt + 12'd1;
    end

    // Completion is flagged as the last VBlank cycle begins; the count steps on that edge.
    if (w_state_nxt == S_VBLANK && w_cnt_nxt == VB_LAST) begin
      w_done_nxt = 1'b1;
      w_fc_nxt   = r_fc + 16'd1;
    end

    w_fv_nxt   = (w_state_nxt == S_SETUP) || (w_state_nxt == S_LINE) ||
                 (w_state_nxt == S_HBLANK) || (w_state_nxt == S_HOLD);
    w_lv_nxt   = (w_state_nxt == S_LINE);
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge pix_clk or posedge pix_rst) begin
    if (pix_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_row   <= '0;
      r_ramp  <= 12'd0;
      r_fv    <= 1'b0;
      r_lv    <= 1'b0;
      r_d     <= 12'd0;
      r_fc    <= 16'd0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_row   <= w_row_nxt;
      r_ramp  <= w_ramp_nxt;
      r_fv    <= w_fv_nxt;
      r_lv    <= w_lv_nxt;
      r_d     <= w_d_nxt;
      r_fc    <= w_fc_nxt;
      r_done  <= w_done_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign pix_frameValid = r_fv;
  assign pix_lineValid  = r_lv;
  assign pix_d          = r_d;
  assign frameCount     = r_fc;
  assign frameDone      = r_done;
  assign busy           = r_busy;

endmodule
